file_loader: RTL and testbench

FILE_LOADER -- requirements
Module: file_loader

---
 rtl/file_loader_pkg.sv | 16 +
 rtl/file_loader_fifo.sv | 44 ++++
 rtl/file_loader.sv | 218 +++++++++++++++++++++
 tb/tb_file_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/file_loader_pkg.sv
// rtl/file_loader_pkg.sv - command codes and download state encoding for the file loader
package file_loader_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] JMP_OPCODE      = 8'hC3;

  typedef enum logic [1:0] {
    DL_IDLE,
    DL_HDR_HI,
    DL_HDR_LO,
    DL_PAYLOAD
  } dl_state_t;

endpackage

// File: rtl/file_loader_fifo.sv
// rtl/file_loader_fifo.sv - show-ahead synchronous FIFO holding pending {addr,data} writes
module file_loader_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp;
  logic [PW:0]  rp;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign count = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign head  = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/file_loader.sv
// rtl/file_loader.sv - SPI-fed file download engine writing payload bytes into RAM via a FIFO
module file_loader
  import file_loader_pkg::*;
#(
  parameter int                      AW          = 25,
  parameter int                      FIFO_DEPTH  = 4,
  parameter int                      NREGION     = 4,
  parameter logic [NREGION*AW-1:0]   REGION_BASE = {25'h0FFFFF, 25'h100000, 25'h100000, 25'h200000},
  parameter logic [NREGION-1:0]      HDR_MASK    = 4'b0110
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          ss,
  input  logic          sdi,
  output logic          downloading,
  output logic [4:0]    index,
  output logic [AW-1:0] size,
  output logic          overflow,
  output logic          wr,
  input  logic          ack,
  output logic [AW-1:0] a,
  output logic [7:0]    d
);

  localparam int W  = AW + 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (NREGION > 1) ? $clog2(NREGION) : 1;

  logic sck_meta, sck_s, sck_d, ss_meta, ss_s, sdi_meta, sdi_s;
  logic sck_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      {sck_meta, sck_s, sck_d} <= '0;
      {ss_meta, ss_s}          <= '0;
      {sdi_meta, sdi_s}        <= '0;
    end else begin
      {sck_meta, sck_s, sck_d} <= {sck, sck_meta, sck_s};
      {ss_meta, ss_s}          <= {ss, ss_meta};
      {sdi_meta, sdi_s}        <= {sdi, sdi_meta};
    end
  end

  assign sck_rise = sck_s & ~sck_d;

  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic       seen_ss, first, byte_done, rx_is_cmd;
  logic [7:0] rx_byte;

  // Bits are ignored until ss has been seen high, so a frame cut by reset is never half-decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      sr        <= '0;
      seen_ss   <= 1'b0;
      first     <= 1'b1;
      byte_done <= 1'b0;
      rx_is_cmd <= 1'b0;
      rx_byte   <= '0;
    end else begin
      byte_done <= 1'b0;
      if (ss_s) begin
        seen_ss <= 1'b1;
        first   <= 1'b1;
        bit_cnt <= '0;
      end else if (seen_ss && sck_rise) begin
        sr      <= {sr[5:0], sdi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {sr, sdi_s};
          rx_is_cmd <= first;
          first     <= 1'b0;
        end
      end
    end
  end

  logic [7:0]    cmd;
  logic [4:0]    new_index;
  logic [IW-1:0] sel;
  logic [AW-1:0] base;
  logic          hdr_sel;
  dl_state_t     state, state_next;
  logic          data_byte, start_dl, end_dl, dat_byte;

  assign data_byte = byte_done & ~rx_is_cmd;
  assign start_dl  = data_byte && (cmd == UIO_FILE_TX) && rx_byte[0];
  assign end_dl    = data_byte && (cmd == UIO_FILE_TX) && !rx_byte[0];
  assign dat_byte  = data_byte && (cmd == UIO_FILE_TX_DAT) && (state != DL_IDLE);

  // Indices past the last region all share the last region's base and mode.
  always_comb begin
    sel     = '0;
    base    = '0;
    hdr_sel = 1'b0;
    if ({27'd0, new_index} >= 32'(NREGION)) sel = IW'(NREGION - 1);
    else                                     sel = IW'(new_index);
    for (int i = 0; i < NREGION; i++) begin
      if (sel == IW'(i)) begin
        base    = REGION_BASE[i*AW +: AW];
        hdr_sel = HDR_MASK[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= DL_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_dl) begin
      state_next = hdr_sel ? DL_HDR_HI : DL_PAYLOAD;
    end else if (end_dl) begin
      state_next = DL_IDLE;
    end else if (dat_byte) begin
      case (state)
        DL_HDR_HI: state_next = DL_HDR_LO;
        DL_HDR_LO: state_next = DL_PAYLOAD;
        default:   state_next = state;
      endcase
    end
  end

  logic [AW-1:0] ptr;
  logic [7:0]    start_hi;
  logic          push_valid, pend_valid;
  logic [W-1:0]  push_data, pend_data;
  logic          fifo_full, fifo_empty, pop;
  logic [W-1:0]  head;
  logic [CW-1:0] count;

  // The second header entry waits one cycle in pend_* so both land on consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd        <= '0;
      new_index  <= '0;
      index      <= '0;
      size       <= '0;
      overflow   <= 1'b0;
      ptr        <= '0;
      start_hi   <= '0;
      push_valid <= 1'b0;
      push_data  <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      push_valid <= pend_valid;
      push_data  <= pend_data;
      pend_valid <= 1'b0;
      if (push_valid && fifo_full) overflow <= 1'b1;
      if (byte_done && rx_is_cmd) cmd <= rx_byte;
      if (data_byte && (cmd == UIO_FILE_INDEX)) new_index <= rx_byte[4:0];
      if (start_dl) begin
        index      <= new_index;
        size       <= '0;
        overflow   <= 1'b0;
        ptr        <= base;
        push_valid <= 1'b0;
        pend_valid <= 1'b0;
      end else if (dat_byte) begin
        case (state)
          DL_HDR_HI: begin
            push_valid <= 1'b1;
            push_data  <= {AW'(0), JMP_OPCODE};
            start_hi   <= rx_byte;
          end
          DL_HDR_LO: begin
            push_valid <= 1'b1;
            push_data  <= {AW'(1), rx_byte};
            pend_valid <= 1'b1;
            pend_data  <= {AW'(2), start_hi};
            ptr        <= AW'({start_hi, rx_byte});
          end
          default: begin
            push_valid <= 1'b1;
            push_data  <= {ptr, rx_byte};
            ptr        <= ptr + 1'b1;
            size       <= size + 1'b1;
          end
        endcase
      end
    end
  end

  file_loader_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start_dl),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign pop = wr & ack;

  // wr stays up across a pop only when another entry remains behind the popped one.
  always_ff @(posedge clk) begin
    if (reset) wr <= 1'b0;
    else       wr <= !start_dl && (count > {{(CW-1){1'b0}}, pop});
  end

  assign a           = wr ? head[W-1:8] : '0;
  assign d           = wr ? head[7:0]   : '0;
  assign downloading = (state != DL_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_file_loader.sv
// tb/tb_file_loader.sv - directed self-checking bench for file_loader
module tb_file_loader;

  logic        clk = 1'b0;
  logic        reset, sck, ss, sdi, ack;
  logic        downloading, overflow, wr;
  logic [4:0]  index;
  logic [24:0] size, a;
  logic [7:0]  d;

  int errors = 0;
  int checks = 0;
  int ack_mode = 0;
  int ack_cnt = 0;
  logic [24:0] wa_q[$];
  logic [7:0]  wd_q[$];
  bit          wdl_q[$];

  file_loader dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(downloading), .index(index), .size(size), .overflow(overflow),
    .wr(wr), .ack(ack), .a(a), .d(d)
  );

  always #5 clk = ~clk;

  // ack is set for the coming edge, then any write that edge will accept is logged.
  always @(negedge clk) begin
    ack_cnt = ack_cnt + 1;
    case (ack_mode)
      0:       ack = 1'b0;
      1:       ack = 1'b1;
      default: ack = (ack_cnt % 3 == 0);
    endcase
    if (wr && ack && !reset) begin
      wa_q.push_back(a);
      wd_q.push_back(d);
      wdl_q.push_back(downloading);
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #30 sck = 1'b1;
      #30 sck = 1'b0;
    end
  endtask

  // data bytes are packed LSB-first: byte k is data[8*k +: 8]
  task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] data, input int n);
    ss = 1'b0;
    #40;
    spi_bits(cmd, 8);
    for (int k = 0; k < n; k++) spi_bits(data[8*k +: 8], 8);
    #40 ss = 1'b1;
    #100;
  endtask

  task automatic wait_writes(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (wa_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ss = 1'b1; sck = 1'b0; sdi = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
    checks++; if (a !== 25'd0) begin errors++; $display("FAIL reset_a: got %h want 0", a); end
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL reset_d: got %h want 0", d); end
    checks++; if (downloading !== 1'b0) begin errors++; $display("FAIL reset_dl: got %b want 0", downloading); end
    checks++; if (index !== 5'd0 || size !== 25'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_status: got idx=%0d size=%0d ovf=%b want 0 0 0", index, size, overflow);
    end
  endtask

  task automatic test_basic;
    logic [24:0] ea [3] = '{25'h200000, 25'h200001, 25'h200002};
    logic [7:0]  ed [3] = '{8'h11, 8'h22, 8'h33};
    ack_mode = 1;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h55, 64'h00, 1);
    spi_frame(8'h53, 64'h01, 1);
    checks++; if (downloading !== 1'b1) begin errors++; $display("FAIL basic_dl_start: got %b want 1", downloading); end
    spi_frame(8'h54, 64'h332211, 3);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (wa_q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", wa_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++; $display("FAIL basic_write%0d: got (%h,%h) want (%h,%h)", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
    checks++; if (size !== 25'd3) begin errors++; $display("FAIL basic_size: got %0d want 3", size); end
    checks++; if (downloading !== 1'b0) begin errors++; $display("FAIL basic_dl_end: got %b want 0", downloading); end
  endtask

  task automatic test_header;
    logic [24:0] ea [4] = '{25'h0, 25'h1, 25'h2, 25'h1234};
    logic [7:0]  ed [4] = '{8'hC3, 8'h34, 8'h12, 8'hAA};
    ack_mode = 1;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h55, 64'h01, 1);
    spi_frame(8'h53, 64'h01, 1);
    spi_frame(8'h54, 64'hAA3412, 3);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL hdr_count: got %0d want 4", wa_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++; $display("FAIL hdr_write%0d: got (%h,%h) want (%h,%h)", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
    checks++; if (size !== 25'd1) begin errors++; $display("FAIL hdr_size: got %0d want 1", size); end
    checks++; if (index !== 5'd1) begin errors++; $display("FAIL hdr_index: got %0d want 1", index); end
  endtask

  task automatic test_overflow;
    bit ok;
    ack_mode = 0;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h55, 64'h00, 1);
    spi_frame(8'h53, 64'h01, 1);
    spi_frame(8'h54, 64'h060504030201, 6);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (size !== 25'd6) begin errors++; $display("FAIL ovf_size: got %0d want 6", size); end
    checks++; if (wr !== 1'b1 || a !== 25'h200000 || d !== 8'h01) begin
      errors++; $display("FAIL ovf_hold: got wr=%b (%h,%h) want 1 (200000,01)", wr, a, d);
    end
    checks++; if (downloading !== 1'b1) begin errors++; $display("FAIL ovf_dl_hold: got %b want 1", downloading); end
    ack_mode = 1;
    wait_writes(4, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain_timeout: got %0d writes want 4", wa_q.size()); end
    repeat (10) @(negedge clk);
    checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", wa_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (wa_q[i] !== 25'h200000 + 25'(i) || wd_q[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_write%0d: got (%h,%h) want (%h,%h)", i, wa_q[i], wd_q[i], 25'h200000 + 25'(i), 8'(i + 1));
      end
    end
    checks++; if (wdl_q.size() == 4 && wdl_q[3] !== 1'b1) begin errors++; $display("FAIL ovf_dl_last: got %b want 1", wdl_q[3]); end
    checks++; if (downloading !== 1'b0) begin errors++; $display("FAIL ovf_dl_end: got %b want 0", downloading); end
  endtask

  task automatic test_drain;
    bit ok;
    ack_mode = 0;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h53, 64'h01, 1);
    spi_frame(8'h54, 64'hA3A2A1, 3);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (downloading !== 1'b1) begin errors++; $display("FAIL drain_dl_pending: got %b want 1", downloading); end
    ack_mode = 2;
    wait_writes(3, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: got %0d writes want 3", wa_q.size()); end
    else begin
      checks++; if (wdl_q[0] !== 1'b1 || wdl_q[1] !== 1'b1 || wdl_q[2] !== 1'b1) begin
        errors++; $display("FAIL drain_dl_during: got %b%b%b want 111", wdl_q[0], wdl_q[1], wdl_q[2]);
      end
      checks++; if (wa_q[2] !== 25'h200002 || wd_q[2] !== 8'hA3) begin
        errors++; $display("FAIL drain_last: got (%h,%h) want (200002,a3)", wa_q[2], wd_q[2]);
      end
      @(negedge clk);
      checks++; if (downloading !== 1'b0) begin errors++; $display("FAIL drain_dl_fall: got %b want 0", downloading); end
    end
  endtask

  task automatic test_restart;
    ack_mode = 0;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h53, 64'h01, 1);
    spi_frame(8'h54, 64'h8877, 2);
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL restart_pending: got %b want 1", wr); end
    spi_frame(8'h53, 64'h01, 1);
    checks++; if (wr !== 1'b0 || size !== 25'd0 || downloading !== 1'b1) begin
      errors++; $display("FAIL restart_flush: got wr=%b size=%0d dl=%b want 0 0 1", wr, size, downloading);
    end
    ack_mode = 1;
    spi_frame(8'h54, 64'h99, 1);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (wa_q.size() != 1 || wa_q[0] !== 25'h200000 || wd_q[0] !== 8'h99) begin
      errors++; $display("FAIL restart_write: got n=%0d (%h,%h) want 1 (200000,99)", wa_q.size(), wa_q.size() ? wa_q[0] : 25'h0, wd_q.size() ? wd_q[0] : 8'h0);
    end
  endtask

  task automatic test_clamp;
    ack_mode = 1;
    wa_q.delete(); wd_q.delete(); wdl_q.delete();
    spi_frame(8'h55, 64'h09, 1);
    spi_frame(8'h53, 64'h01, 1);
    spi_frame(8'h54, 64'h5A, 1);
    spi_frame(8'h53, 64'h00, 1);
    checks++; if (wa_q.size() != 1 || wa_q[0] !== 25'h0FFFFF || wd_q[0] !== 8'h5A) begin
      errors++; $display("FAIL clamp_write: got n=%0d (%h,%h) want 1 (0fffff,5a)", wa_q.size(), wa_q.size() ? wa_q[0] : 25'h0, wd_q.size() ? wd_q[0] : 8'h0);
    end
    checks++; if (index !== 5'd9 || size !== 25'd1) begin
      errors++; $display("FAIL clamp_status: got idx=%0d size=%0d want 9 1", index, size);
    end
  endtask

  task automatic test_reset_mid;
    ack_mode = 1;
    ss = 1'b0;
    #40;
    spi_bits(8'hA5, 4);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (wr !== 1'b0 || a !== 25'd0 || d !== 8'd0 || downloading !== 1'b0 ||
                  index !== 5'd0 || size !== 25'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got wr=%b a=%h d=%h dl=%b idx=%0d size=%0d ovf=%b want all 0",
                         wr, a, d, downloading, index, size, overflow);
    end
    spi_bits(8'h50, 4);
    spi_bits(8'h53, 8);
    spi_bits(8'h01, 8);
    #100;
    checks++; if (downloading !== 1'b0) begin errors++; $display("FAIL midreset_ignored: got %b want 0", downloading); end
    ss = 1'b1;
    #100;
    spi_frame(8'h53, 64'h01, 1);
    checks++; if (downloading !== 1'b1 || index !== 5'd0) begin
      errors++; $display("FAIL midreset_resume: got dl=%b idx=%0d want 1 0", downloading, index);
    end
    spi_frame(8'h53, 64'h00, 1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_header;
    test_overflow;
    test_drain;
    test_restart;
    test_clamp;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
